// File: rtl/lc3_reg_file.sv
// lc3_reg_file
// LC-3 general-purpose register file (R0-R7) fed by an in-order write-back
// queue. Results are accepted over a valid/ready handshake, forwarded to both
// read ports while still queued, and committed one per cycle when commit_en
// is high. Committed results optionally load the NZP condition codes.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   rd_a_sel   read port A select      rd_a_data  read port A data (comb)
//   rd_b_sel   read port B select      rd_b_data  read port B data (comb)
//   wb_valid   write-back request      wb_ready   queue has a free entry
//   wb_dest    destination register    wb_data    result value
//   wb_set_cc  result loads NZP on commit
//   commit_en  allow queue head to commit this cycle
//   cc_nzp     condition codes {N,Z,P} (registered)
//   wb_count   occupied queue entries (registered)
module lc3_reg_file #(
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rd_a_sel,
  output logic [15:0] rd_a_data,
  input  logic [2:0]  rd_b_sel,
  output logic [15:0] rd_b_data,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  wb_dest,
  input  logic [15:0] wb_data,
  input  logic        wb_set_cc,
  input  logic        commit_en,
  output logic [2:0]  cc_nzp,
  output logic [2:0]  wb_count
);

  logic [15:0] regs [8];

  // Queue storage is sized for the largest legal depth so the 2-bit
  // pointers index it directly; entries beyond WB_DEPTH are never reached.
  logic [2:0]  q_dest [4];
  logic [15:0] q_data [4];
  logic        q_cc   [4];

  logic [1:0] head;
  logic [1:0] tail;
  logic [2:0] count;

  logic do_enq;
  logic do_com;

  assign wb_ready = (count < 3'(WB_DEPTH));
  assign wb_count = count;
  assign do_enq   = wb_valid && wb_ready;
  assign do_com   = commit_en && (count != 3'd0);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'(WB_DEPTH - 1)) return 2'd0;
    return p + 2'd1;
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])          return 3'b100;
    if (v == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  // Walk occupied entries from oldest to youngest; a later match overrides
  // an earlier one, so the youngest matching entry wins.
  function automatic logic [15:0] fwd(input logic [2:0] sel);
    logic [15:0] r;
    logic [2:0]  idx;
    r = regs[sel];
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = {1'b0, head} + 3'(k);
      if (idx >= 3'(WB_DEPTH)) idx = idx - 3'(WB_DEPTH);
      if ((3'(k) < count) && (q_dest[idx[1:0]] == sel)) r = q_data[idx[1:0]];
    end
    return r;
  endfunction

  always_comb begin
    rd_a_data = fwd(rd_a_sel);
    rd_b_data = fwd(rd_b_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      cc_nzp <= 3'b010;
      count  <= 3'd0;
      head   <= 2'd0;
      tail   <= 2'd0;
    end else begin
      if (do_enq) begin
        q_dest[tail] <= wb_dest;
        q_data[tail] <= wb_data;
        q_cc[tail]   <= wb_set_cc;
        tail         <= ptr_inc(tail);
      end
      if (do_com) begin
        regs[q_dest[head]] <= q_data[head];
        if (q_cc[head]) cc_nzp <= nzp_of(q_data[head]);
        head <= ptr_inc(head);
      end
      if (do_enq && !do_com)      count <= count + 3'd1;
      else if (!do_enq && do_com) count <= count - 3'd1;
    end
  end

endmodule

// File: tb/tb_lc3_reg_file.sv
module tb_lc3_reg_file;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_a_sel, rd_b_sel;
  logic [15:0] rd_a_data, rd_b_data;
  logic        wb_valid, wb_ready;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_set_cc, commit_en;
  logic [2:0]  cc_nzp, wb_count;

  always #5 clk = ~clk;

  lc3_reg_file #(.WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_a_sel(rd_a_sel), .rd_a_data(rd_a_data),
    .rd_b_sel(rd_b_sel), .rd_b_data(rd_b_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest(wb_dest), .wb_data(wb_data), .wb_set_cc(wb_set_cc),
    .commit_en(commit_en), .cc_nzp(cc_nzp), .wb_count(wb_count)
  );

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    bit          sc;
  } ent_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cc;
    logic [2:0]  cnt;
    logic        rdy;
  } exp_t;

  // Reference model: plain array of registers plus an ordered list of
  // pending results.
  logic [15:0] m_regs [8];
  ent_t        m_q[$];
  logic [2:0]  m_cc;
  exp_t        sb[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [15:0] m_read(input logic [2:0] s);
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].dest == s) return m_q[i].data;
    return m_regs[s];
  endfunction

  task automatic model_step(input bit r, input bit va, input logic [2:0] d,
                            input logic [15:0] dat, input bit sc, input bit ce);
    bit   enq;
    ent_t h;
    if (r) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_q.delete();
      m_cc = 3'b010;
    end else begin
      enq = va && (m_q.size() < DEPTH);
      if (ce && m_q.size() != 0) begin
        h = m_q.pop_front();
        m_regs[h.dest] = h.data;
        if (h.sc) begin
          if (h.data >= 16'h8000)     m_cc = 3'b100;
          else if (h.data == 16'h0) m_cc = 3'b010;
          else                        m_cc = 3'b001;
        end
      end
      if (enq) m_q.push_back('{dest: d, data: dat, sc: sc});
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
  endtask

  // One clock cycle: drive inputs, record what the outputs must show during
  // this cycle, then advance the model across the edge.
  task automatic cyc(input bit r, input bit va, input logic [2:0] d,
                     input logic [15:0] dat, input bit sc, input bit ce,
                     input logic [2:0] sa, input logic [2:0] sbs, input bit chk);
    exp_t e;
    rst = r; wb_valid = va; wb_dest = d; wb_data = dat; wb_set_cc = sc;
    commit_en = ce; rd_a_sel = sa; rd_b_sel = sbs;
    if (chk) begin
      e.a   = m_read(sa);
      e.b   = m_read(sbs);
      e.cc  = m_cc;
      e.cnt = 3'(m_q.size());
      e.rdy = (m_q.size() < DEPTH);
      sb.push_back(e);
    end
    @(posedge clk);
    model_step(r, va, d, dat, sc, ce);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rd_a_data", rd_a_data, e.a);
      check("rd_b_data", rd_b_data, e.b);
      check("cc_nzp",    16'(cc_nzp), 16'(e.cc));
      check("wb_count",  16'(wb_count), 16'(e.cnt));
      check("wb_ready",  16'(wb_ready), 16'(e.rdy));
    end
  end

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h8000 | 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
    m_cc = 3'bxxx;

    // Reset and read every register on both ports.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, 3'(i), 3'(7 - i), 1);

    // Negative result then zero result into R3, commit enabled.
    cyc(0, 1, 3, 16'h8001, 1, 1, 3, 0, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 3, 3, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 3, 3, 1);
    cyc(0, 1, 3, 16'h0000, 1, 1, 3, 0, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 3, 3, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 3, 3, 1);

    // Fill with duplicate destinations, hold off a third request, then drain.
    cyc(0, 1, 1, 16'h0005, 0, 0, 1, 1, 1);
    cyc(0, 1, 1, 16'h0007, 0, 0, 1, 0, 1);
    cyc(0, 1, 2, 16'h9999, 1, 0, 1, 2, 1);
    cyc(0, 1, 2, 16'h9999, 1, 0, 1, 2, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 2, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 2, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 1, 2, 1);

    // Full queue, commit enabled, valid held: no enqueue on the commit edge.
    cyc(0, 1, 4, 16'h0011, 1, 0, 4, 5, 1);
    cyc(0, 1, 5, 16'h0022, 1, 0, 4, 5, 1);
    cyc(0, 1, 4, 16'haaaa, 0, 1, 4, 5, 1);
    cyc(0, 1, 4, 16'haaaa, 0, 1, 4, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 4, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 4, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 4, 5, 1);

    // Result that leaves NZP alone.
    cyc(0, 1, 6, 16'h1234, 0, 1, 6, 6, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 6, 6, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 6, 4, 1);

    // Reset with two entries queued: neither commits.
    cyc(0, 1, 2, 16'hf00d, 1, 0, 2, 5, 1);
    cyc(0, 1, 5, 16'h0001, 1, 0, 2, 5, 1);
    cyc(1, 0, 0, 16'h0000, 0, 1, 2, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 2, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 2, 5, 1);
    cyc(0, 0, 0, 16'h0000, 0, 1, 6, 3, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          3'($urandom), pick_data(), 1'($urandom),
          ($urandom_range(0, 2) != 0), 3'($urandom), 3'($urandom), 1);

    rst = 1'b0; wb_valid = 1'b0; commit_en = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
